axi4_lite_regfile: RTL and testbench
====================================

# axi4_lite_regfile

Parametrised AXI4-Lite slave register file, next generation of the team's AXI4-Lite memory slave. Read and write paths run independently and concurrently. AW and W are accepted in any order through one-entry holding registers. Byte-addressed words support per-lane strobes. Out-of-range accesses return SLVERR and are counted in a saturating error counter.

## Interface
- ADDRESS_WIDTH, 32, AXI address width in bits (byte address)
- DATA_WIDTH, 32, data width; 32 or 64 only
- DATA_DEPTH, 32, number of DATA_WIDTH words; any value 1..2^(ADDRESS_WIDTH-LSB), LSB = log2(DATA_WIDTH/8)
- ACLK  input  1  single clock, all logic on rising edge
- ARESET  input  1  asynchronous, active-high reset
- S_AXI_AWADDR / S_AXI_AWVALID / S_AXI_AWREADY  in/in/out  ADDRESS_WIDTH/1/1  write address channel
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID / S_AXI_WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- S_AXI_BRESP / S_AXI_BVALID / S_AXI_BREADY  out/out/in  2/1/1  write response
- S_AXI_ARADDR / S_AXI_ARVALID / S_AXI_ARREADY  in/in/out  ADDRESS_WIDTH/1/1  read address
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID / S_AXI_RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data
- ERR_COUNT  output  8  saturating count of SLVERR responses, both paths

## Operation
- Decode: word index = ADDR[ADDRESS_WIDTH-1:LSB]. Low LSB bits are ignored; unaligned addresses access the containing word. Index >= DATA_DEPTH is out of range.
- Write path: the AW and W holding registers each have a full flag.
  - AWREADY = registered !aw_full. WREADY = registered !w_full.
  - An AW handshake sets aw_full and latches the address. A W handshake sets w_full and latches data and strobe. The two may occur in either order or the same cycle.
  - Commit occurs on any edge where aw_full & w_full & (!BVALID | BREADY):
    - in range: for each lane i with WSTRB[i]=1, mem[idx][8i+:8] <= data; other lanes are unchanged. WSTRB=0 writes nothing and still returns OKAY.
    - out of range: no memory change; BRESP=2'b10.
    - In both cases commit clears both full flags and sets BVALID; BRESP=2'b00 when in range.
  - A B handshake clears BVALID, unless a commit occurs on the same edge.
- Read path has two states: R_IDLE and R_DATA.
  - R_IDLE: ARREADY=1. An AR handshake registers RDATA=mem[idx], or 0 if out of range, and RRESP=00 or 10. Then RVALID=1, ARREADY=0, state R_DATA.
  - R_DATA: RDATA, RRESP and RVALID are held stable until RREADY. On the R handshake: RVALID=0, ARREADY=1, state R_IDLE.
- Read and write collision: if a read captures a word on the same edge as a commit to that word, the read returns the old value (read-first).
- ERR_COUNT increments by 1 per SLVERR issued (write commit or read capture) and saturates at 255. A simultaneous read and write error adds 2, clamped at 255.
- Reset (ARESET high, any time) has immediate effect:
  - all memory words, holding registers, flags and ERR_COUNT are set to 0
  - all outputs are set to 0, including all READY and VALID outputs
  - in-flight transactions are discarded with no response
- Release: on the first rising edge after ARESET falls, AWREADY, WREADY and ARREADY go to 1.

## Timing
- Write latency: BVALID rises on the edge after the later of the AW and W handshake edges, when B is free.
- Write throughput: one write per 2 cycles with BREADY held high, because the readies reassert on the commit edge.
- Back-pressure: if BVALID is stalled, the holding registers stay full and AWREADY and WREADY stay low. No second write is accepted until the commit.
- Read latency: RVALID rises on the AR handshake edge, with data valid in the same cycle.
- Read throughput: one read per 2 cycles with RREADY held high.
- All outputs are driven directly from flops; there is no combinational path from input to output.

## Test plan
- Reset, then AW 0x08 and W 0xDEADBEEF with WSTRB=F in the same cycle, BREADY=1:
  - BVALID high for 1 cycle, BRESP=00.
  - Then AR 0x08 returns RDATA=0xDEADBEEF, RRESP=00.
- W 0x11223344 two cycles before AW 0x0C, WSTRB=4'b0101, over existing 0xFFFFFFFF:
  - readback 0xFF22FF44.
  - WREADY stays low between the W handshake and the commit.
- Out-of-range access with DATA_DEPTH=32, write to 0x80 then read 0x80:
  - BRESP=10, RRESP=10, RDATA=0, memory unchanged.
  - ERR_COUNT=2.
  - 300 further errors saturate ERR_COUNT at 255.
- BREADY held low for 5 cycles after the first write, second AW/W offered:
  - AWREADY and WREADY stay 0 and BVALID stays high.
  - The second write commits on the BREADY edge and BVALID stays high.
- Concurrent traffic, read of 0x04 issued on the same edge as the commit of 0xA5A5A5A5 to 0x04:
  - old value returned.
  - A later read returns 0xA5A5A5A5.
  - Unaligned read 0x06 returns the same word.
- ARESET pulsed while RVALID=1 and aw_full=1:
  - all outputs 0 immediately and ERR_COUNT=0.
  - after release, readies are 1 and a read of 0x08 returns 0.

Source files
------------

// File: rtl/axi4_lite_regfile.sv
// ---------------------------------------------------------------------------
// axi4_lite_regfile
//
// Purpose:
//    AXI4-Lite slave register file. The read and write paths are independent
//    and run concurrently. AW and W are accepted in any order through
//    one-entry holding registers. Writes honour per-byte strobes. Accesses
//    whose word index falls outside DATA_DEPTH get SLVERR, and every SLVERR
//    bumps a saturating 8-bit error counter.
//
// Parameters:
//    ADDRESS_WIDTH  byte-address width of the AXI address channels
//    DATA_WIDTH     bus/word width, 32 or 64
//    DATA_DEPTH     number of DATA_WIDTH words held in the file
//
// Ports:
//    ACLK            single clock, everything on the rising edge
//    ARESET          asynchronous active-high reset
//    S_AXI_AW*       write address channel (ADDR, VALID in; READY out)
//    S_AXI_W*        write data channel (DATA, STRB, VALID in; READY out)
//    S_AXI_B*        write response channel (RESP, VALID out; READY in)
//    S_AXI_AR*       read address channel (ADDR, VALID in; READY out)
//    S_AXI_R*        read data channel (DATA, RESP, VALID out; READY in)
//    ERR_COUNT       saturating count of SLVERR responses on both paths
// ---------------------------------------------------------------------------
module axi4_lite_regfile #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int DATA_DEPTH    = 32
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [ADDRESS_WIDTH-1:0]  S_AXI_AWADDR,
   input  logic                      S_AXI_AWVALID,
   output logic                      S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                      S_AXI_WVALID,
   output logic                      S_AXI_WREADY,
   output logic [1:0]                S_AXI_BRESP,
   output logic                      S_AXI_BVALID,
   input  logic                      S_AXI_BREADY,
   input  logic [ADDRESS_WIDTH-1:0]  S_AXI_ARADDR,
   input  logic                      S_AXI_ARVALID,
   output logic                      S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                S_AXI_RRESP,
   output logic                      S_AXI_RVALID,
   input  logic                      S_AXI_RREADY,
   output logic [7:0]                ERR_COUNT
);

   localparam int LSB        = (DATA_WIDTH == 64) ? 3 : 2;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_WIDTH  = ADDRESS_WIDTH - LSB;
   localparam int MEM_AW     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   localparam logic [IDX_WIDTH:0] DEPTH_LIMIT = (IDX_WIDTH + 1)'(DATA_DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } read_state_t;

   logic [DATA_WIDTH-1:0]  mem [DATA_DEPTH];

   logic                   aw_full;
   logic                   w_full;
   logic                   aw_full_next;
   logic                   w_full_next;
   logic [IDX_WIDTH-1:0]   aw_idx_q;
   logic [DATA_WIDTH-1:0]  w_data_q;
   logic [STRB_WIDTH-1:0]  w_strb_q;
   read_state_t            read_state;

   logic [IDX_WIDTH-1:0]   ar_idx;
   logic [MEM_AW-1:0]      aw_mem_idx;
   logic [MEM_AW-1:0]      ar_mem_idx;
   logic                   aw_in_range;
   logic                   ar_in_range;
   logic                   aw_hs;
   logic                   w_hs;
   logic                   ar_hs;
   logic                   commit;
   logic                   w_err;
   logic                   r_err;
   logic [8:0]             err_sum;
   logic                   unused_addr_bits;

   // Byte-offset bits below LSB never affect which word is accessed, so an
   // unaligned address simply lands on its containing word.
   assign unused_addr_bits = &{1'b0, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

   assign ar_idx      = S_AXI_ARADDR[ADDRESS_WIDTH-1:LSB];
   assign aw_mem_idx  = aw_idx_q[MEM_AW-1:0];
   assign ar_mem_idx  = ar_idx[MEM_AW-1:0];
   assign aw_in_range = ({1'b0, aw_idx_q} < DEPTH_LIMIT);
   assign ar_in_range = ({1'b0, ar_idx} < DEPTH_LIMIT);

   assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;

   // A write retires only when both halves are held and the B channel is
   // free (or being freed on this very edge).
   assign commit = aw_full & w_full & (~S_AXI_BVALID | S_AXI_BREADY);
   assign w_err  = commit & ~aw_in_range;
   assign r_err  = ar_hs & ~ar_in_range;
   assign err_sum = {1'b0, ERR_COUNT} + {8'd0, w_err} + {8'd0, r_err};

   // Next-state of the two holding-register flags. The readies are the
   // registered inverse of these, which is why they reassert on the commit
   // edge itself rather than one cycle later.
   always_comb begin
      aw_full_next = aw_full;
      w_full_next  = w_full;
      if (commit) begin
         aw_full_next = 1'b0;
         w_full_next  = 1'b0;
      end else begin
         if (aw_hs) aw_full_next = 1'b1;
         if (w_hs)  w_full_next  = 1'b1;
      end
   end

   // Write-path control: capture AW and W into their holding registers,
   // drive the registered readies, and raise BVALID/BRESP on commit. A new
   // commit on the same edge as a B handshake keeps BVALID high for the
   // next response.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         aw_idx_q      <= '0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
      end else begin
         aw_full       <= aw_full_next;
         w_full        <= w_full_next;
         S_AXI_AWREADY <= ~aw_full_next;
         S_AXI_WREADY  <= ~w_full_next;
         if (aw_hs) begin
            aw_idx_q <= S_AXI_AWADDR[ADDRESS_WIDTH-1:LSB];
         end
         if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
         end
         if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
         end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
      end
   end

   // Storage array. Only the strobed byte lanes of an in-range commit are
   // touched; an all-zero strobe is a legal no-op write.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < DATA_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (commit && aw_in_range) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (w_strb_q[i]) begin
               mem[aw_mem_idx][8*i +: 8] <= w_data_q[8*i +: 8];
            end
         end
      end
   end

   // Read path state machine. The word is captured on the AR handshake edge
   // and held until the master takes it. Because the memory update above is
   // non-blocking, a capture on the same edge as a commit to that word sees
   // the old contents. Leaving reset, ARREADY comes up on the first edge.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         read_state    <= R_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= RESP_OKAY;
      end else begin
         case (read_state)
            R_IDLE: begin
               if (ar_hs) begin
                  S_AXI_RDATA   <= ar_in_range ? mem[ar_mem_idx] : '0;
                  S_AXI_RRESP   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                  S_AXI_RVALID  <= 1'b1;
                  S_AXI_ARREADY <= 1'b0;
                  read_state    <= R_DATA;
               end else begin
                  S_AXI_ARREADY <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  S_AXI_RVALID  <= 1'b0;
                  S_AXI_ARREADY <= 1'b1;
                  read_state    <= R_IDLE;
               end
            end
            default: begin
               read_state <= R_IDLE;
            end
         endcase
      end
   end

   // Error counter: both paths may report on the same edge, so the sum is
   // formed one bit wider and clamped at 255.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         ERR_COUNT <= 8'd0;
      end else if (w_err || r_err) begin
         ERR_COUNT <= err_sum[8] ? 8'hFF : err_sum[7:0];
      end
   end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_regfile
//
// Purpose:
//    Directed self-checking bench for axi4_lite_regfile with default
//    parameters (32-bit address, 32-bit data, 32 words). A behavioural
//    reference model tracks the expected outputs; a compare process checks
//    them every falling edge, and the directed sequence adds hand-computed
//    literal checks.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_axi4_lite_regfile;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [31:0] S_AXI_AWADDR = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b1;
   logic [31:0] S_AXI_ARADDR = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b1;
   logic [7:0]  ERR_COUNT;

   int total = 0;
   int bad   = 0;

   axi4_lite_regfile #(
      .ADDRESS_WIDTH(32),
      .DATA_WIDTH(32),
      .DATA_DEPTH(32)
   ) dut (
      .ACLK(ACLK),
      .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR),
      .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA),
      .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP),
      .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR),
      .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA),
      .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID),
      .S_AXI_RREADY(S_AXI_RREADY),
      .ERR_COUNT(ERR_COUNT)
   );

   always #5 ACLK = ~ACLK;

   // ---------------- reference model ----------------
   logic [31:0] memModel [32];
   logic        awHeld, wHeld;
   logic [31:0] awAddrHeld, wDataHeld;
   logic [3:0]  wStrbHeld;
   logic        expAwready, expWready, expBvalid, expArready, expRvalid;
   logic [1:0]  expBresp, expRresp;
   logic [31:0] expRdata;
   int          expErr;

   // Compares one value against its expected value and counts the result.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // A handshake wait that ran out of cycles counts as a failed comparison.
   task automatic reportTimeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out waiting for handshake at %0t", name, $time);
   endtask

   task automatic modelReset();
      for (int i = 0; i < 32; i++) memModel[i] = '0;
      awHeld = 1'b0;     wHeld = 1'b0;
      awAddrHeld = '0;   wDataHeld = '0;   wStrbHeld = '0;
      expAwready = 1'b0; expWready = 1'b0; expArready = 1'b0;
      expBvalid = 1'b0;  expRvalid = 1'b0;
      expBresp = 2'b00;  expRresp = 2'b00; expRdata = '0;
      expErr = 0;
   endtask

   // One clock of the model: a word address is addr/4, anything from word 32
   // up is an error. Reads look at memory before any write on the same edge.
   task automatic modelStep();
      logic        awHs, wHs, arHs, commit;
      int          errs;
      int          widx;
      logic [31:0] mask;
      awHs   = S_AXI_AWVALID && expAwready;
      wHs    = S_AXI_WVALID && expWready;
      arHs   = S_AXI_ARVALID && expArready;
      commit = awHeld && wHeld && (!expBvalid || S_AXI_BREADY);
      errs   = 0;
      if (expRvalid) begin
         if (S_AXI_RREADY) begin
            expRvalid  = 1'b0;
            expArready = 1'b1;
         end
      end else if (arHs) begin
         widx = int'(S_AXI_ARADDR / 32'd4);
         if (widx < 32) begin
            expRdata = memModel[widx];
            expRresp = 2'b00;
         end else begin
            expRdata = '0;
            expRresp = 2'b10;
            errs++;
         end
         expRvalid  = 1'b1;
         expArready = 1'b0;
      end else begin
         expArready = 1'b1;
      end
      if (commit) begin
         widx = int'(awAddrHeld / 32'd4);
         if (widx < 32) begin
            mask = '0;
            for (int lane = 0; lane < 4; lane++)
               if (wStrbHeld[lane]) mask = mask | (32'hFF << (8 * lane));
            memModel[widx] = (memModel[widx] & ~mask) | (wDataHeld & mask);
            expBresp = 2'b00;
         end else begin
            expBresp = 2'b10;
            errs++;
         end
         expBvalid = 1'b1;
         awHeld = 1'b0;
         wHeld  = 1'b0;
      end else if (expBvalid && S_AXI_BREADY) begin
         expBvalid = 1'b0;
      end
      if (awHs) begin
         awHeld = 1'b1;
         awAddrHeld = S_AXI_AWADDR;
      end
      if (wHs) begin
         wHeld = 1'b1;
         wDataHeld = S_AXI_WDATA;
         wStrbHeld = S_AXI_WSTRB;
      end
      expAwready = !awHeld;
      expWready  = !wHeld;
      expErr = (expErr + errs > 255) ? 255 : expErr + errs;
   endtask

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) modelReset();
      else        modelStep();
   end

   // Outputs only change on rising edges or reset, so the falling edge is a
   // stable point to compare against the model.
   always @(negedge ACLK) begin
      checkOutput("awready", S_AXI_AWREADY, expAwready);
      checkOutput("wready",  S_AXI_WREADY,  expWready);
      checkOutput("bvalid",  S_AXI_BVALID,  expBvalid);
      checkOutput("arready", S_AXI_ARREADY, expArready);
      checkOutput("rvalid",  S_AXI_RVALID,  expRvalid);
      checkOutput("err_count", ERR_COUNT,   expErr[7:0]);
      if (expBvalid) checkOutput("bresp", S_AXI_BRESP, expBresp);
      if (expRvalid) begin
         checkOutput("rdata", S_AXI_RDATA, expRdata);
         checkOutput("rresp", S_AXI_RRESP, expRresp);
      end
   end

   // ---------------- drivers ----------------
   // Offers AW and W together and drops each once it has been taken.
   task automatic writeWord(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
      int   guard;
      logic awGo, wGo;
      S_AXI_AWADDR = addr;  S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA  = data;  S_AXI_WSTRB = strb;  S_AXI_WVALID = 1'b1;
      guard = 0;
      while ((S_AXI_AWVALID || S_AXI_WVALID) && guard < 50) begin
         awGo = S_AXI_AWVALID && S_AXI_AWREADY;
         wGo  = S_AXI_WVALID && S_AXI_WREADY;
         @(negedge ACLK);
         if (awGo) S_AXI_AWVALID = 1'b0;
         if (wGo)  S_AXI_WVALID  = 1'b0;
         guard++;
      end
      if (S_AXI_AWVALID || S_AXI_WVALID) begin
         reportTimeout("write_handshake");
         S_AXI_AWVALID = 1'b0;
         S_AXI_WVALID  = 1'b0;
      end
   endtask

   // Issues one read and returns the data seen while RVALID is high.
   task automatic readWord(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int   guard;
      logic go;
      S_AXI_ARADDR = addr;
      S_AXI_ARVALID = 1'b1;
      guard = 0;
      while (S_AXI_ARVALID && guard < 50) begin
         go = S_AXI_ARREADY;
         @(negedge ACLK);
         if (go) S_AXI_ARVALID = 1'b0;
         guard++;
      end
      if (S_AXI_ARVALID) begin
         reportTimeout("ar_handshake");
         S_AXI_ARVALID = 1'b0;
      end
      guard = 0;
      while (!S_AXI_RVALID && guard < 50) begin
         @(negedge ACLK);
         guard++;
      end
      if (!S_AXI_RVALID) reportTimeout("rvalid_wait");
      data = S_AXI_RDATA;
      resp = S_AXI_RRESP;
   endtask

   // ---------------- directed sequence ----------------
   task automatic applyStimulus();
      logic [31:0] rd;
      logic [1:0]  rr;

      // Reset and release
      repeat (2) @(negedge ACLK);
      checkOutput("reset_awready", S_AXI_AWREADY, 1'b0);
      checkOutput("reset_arready", S_AXI_ARREADY, 1'b0);
      checkOutput("reset_err", ERR_COUNT, 8'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      checkOutput("release_awready", S_AXI_AWREADY, 1'b1);
      checkOutput("release_wready",  S_AXI_WREADY,  1'b1);
      checkOutput("release_arready", S_AXI_ARREADY, 1'b1);

      // Simultaneous AW/W, single-cycle BVALID, readback
      writeWord(32'h08, 32'hDEADBEEF, 4'hF);
      @(negedge ACLK);
      checkOutput("t1_bvalid", S_AXI_BVALID, 1'b1);
      checkOutput("t1_bresp",  S_AXI_BRESP,  2'b00);
      @(negedge ACLK);
      checkOutput("t1_bvalid_drop", S_AXI_BVALID, 1'b0);
      readWord(32'h08, rd, rr);
      checkOutput("t1_rdata", rd, 32'hDEADBEEF);
      checkOutput("t1_rresp", rr, 2'b00);

      // W leads AW by two cycles, partial strobe over all-ones
      writeWord(32'h0C, 32'hFFFFFFFF, 4'hF);
      repeat (2) @(negedge ACLK);
      S_AXI_WDATA = 32'h11223344;  S_AXI_WSTRB = 4'b0101;  S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_WVALID = 1'b0;
      checkOutput("t2_wready_held1", S_AXI_WREADY, 1'b0);
      @(negedge ACLK);
      checkOutput("t2_wready_held2", S_AXI_WREADY, 1'b0);
      S_AXI_AWADDR = 32'h0C;  S_AXI_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;
      checkOutput("t2_wready_held3", S_AXI_WREADY, 1'b0);
      @(negedge ACLK);
      checkOutput("t2_wready_back", S_AXI_WREADY, 1'b1);
      checkOutput("t2_bvalid", S_AXI_BVALID, 1'b1);
      readWord(32'h0C, rd, rr);
      checkOutput("t2_rdata", rd, 32'hFF22FF44);

      // Out-of-range write and read, then saturate the error counter
      writeWord(32'h80, 32'h12345678, 4'hF);
      @(negedge ACLK);
      checkOutput("t3_bresp", S_AXI_BRESP, 2'b10);
      @(negedge ACLK);
      readWord(32'h80, rd, rr);
      checkOutput("t3_rdata", rd, 32'h0);
      checkOutput("t3_rresp", rr, 2'b10);
      checkOutput("t3_err2", ERR_COUNT, 8'd2);
      readWord(32'h00, rd, rr);
      checkOutput("t3_word0_untouched", rd, 32'h0);
      for (int k = 0; k < 300; k++) readWord(32'h80 + 32'(k) * 32'd4, rd, rr);
      checkOutput("t3_err_sat", ERR_COUNT, 8'd255);

      // BVALID stalled: second write parks in the holding registers
      S_AXI_BREADY = 1'b0;
      writeWord(32'h10, 32'hCAFEF00D, 4'hF);
      S_AXI_AWADDR = 32'h14;  S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h0BADBEEF;  S_AXI_WSTRB = 4'hF;  S_AXI_WVALID = 1'b1;
      repeat (2) @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("t4_awready_low", S_AXI_AWREADY, 1'b0);
         checkOutput("t4_wready_low",  S_AXI_WREADY,  1'b0);
         checkOutput("t4_bvalid_high", S_AXI_BVALID,  1'b1);
         @(negedge ACLK);
      end
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      checkOutput("t4_bvalid_second", S_AXI_BVALID, 1'b1);
      checkOutput("t4_awready_back", S_AXI_AWREADY, 1'b1);
      @(negedge ACLK);
      checkOutput("t4_bvalid_done", S_AXI_BVALID, 1'b0);
      readWord(32'h14, rd, rr);
      checkOutput("t4_rdata_second", rd, 32'h0BADBEEF);
      readWord(32'h10, rd, rr);
      checkOutput("t4_rdata_first", rd, 32'hCAFEF00D);

      // Read capture on the same edge as a commit to the same word
      writeWord(32'h04, 32'h01234567, 4'hF);
      repeat (2) @(negedge ACLK);
      S_AXI_AWADDR = 32'h04;  S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'hA5A5A5A5;  S_AXI_WSTRB = 4'hF;  S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARADDR = 32'h04;  S_AXI_ARVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b0;
      checkOutput("t5_collide_rvalid", S_AXI_RVALID, 1'b1);
      checkOutput("t5_collide_bvalid", S_AXI_BVALID, 1'b1);
      checkOutput("t5_read_first", S_AXI_RDATA, 32'h01234567);
      @(negedge ACLK);
      readWord(32'h04, rd, rr);
      checkOutput("t5_new_value", rd, 32'hA5A5A5A5);
      readWord(32'h06, rd, rr);
      checkOutput("t5_unaligned", rd, 32'hA5A5A5A5);
      @(negedge ACLK);

      // Reset in the middle of traffic
      S_AXI_RREADY = 1'b0;
      S_AXI_ARADDR = 32'h08;  S_AXI_ARVALID = 1'b1;
      S_AXI_AWADDR = 32'h20;  S_AXI_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b0;
      S_AXI_AWVALID = 1'b0;
      checkOutput("t6_rvalid_before", S_AXI_RVALID, 1'b1);
      #2 ARESET = 1'b1;
      #1;
      checkOutput("t6_awready_zero", S_AXI_AWREADY, 1'b0);
      checkOutput("t6_wready_zero",  S_AXI_WREADY,  1'b0);
      checkOutput("t6_arready_zero", S_AXI_ARREADY, 1'b0);
      checkOutput("t6_bvalid_zero",  S_AXI_BVALID,  1'b0);
      checkOutput("t6_rvalid_zero",  S_AXI_RVALID,  1'b0);
      checkOutput("t6_rdata_zero",   S_AXI_RDATA,   32'h0);
      checkOutput("t6_err_zero",     ERR_COUNT,     8'd0);
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      checkOutput("t6_awready_up", S_AXI_AWREADY, 1'b1);
      checkOutput("t6_wready_up",  S_AXI_WREADY,  1'b1);
      checkOutput("t6_arready_up", S_AXI_ARREADY, 1'b1);
      S_AXI_RREADY = 1'b1;
      readWord(32'h08, rd, rr);
      checkOutput("t6_rdata_cleared", rd, 32'h0);
      checkOutput("t6_rresp", rr, 2'b00);
      repeat (2) @(negedge ACLK);
   endtask

   initial begin
      $display("[TB] starting axi4_lite_regfile directed test");
      applyStimulus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net in case some wait never resolves.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      total++;
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
